// File: rtl/rffe_spi_txn_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rffe_spi_txn_sequencer
// Description : Hardware master for the RFFE SPI core register port. Arbitrates
//               NUM_REQ requesters and runs one 2-byte SPI transaction per
//               grant (command byte, data byte) with SS held low throughout.
//               Optional macro RFFE_SPI_SEQ_STRICT_PRIO_EN selects fixed
//               priority (lowest index wins) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module rffe_spi_txn_sequencer #(
  parameter int          NUM_REQ    = 2,
  parameter int          POLL_LIMIT = 255,
  parameter logic [15:0] SS_MASK    = 16'h0001
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_wr,
  input  logic [NUM_REQ*7-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 spi_select,
  output logic                 spi_read_n,
  output logic                 spi_write_n,
  output logic [2:0]           spi_mem_addr,
  output logic [15:0]          spi_wdata,
  input  logic [15:0]          spi_rdata
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (POLL_LIMIT > 255) ? $clog2(POLL_LIMIT + 1) : 8;

  // Each core access is two active cycles followed by one idle gap cycle.
  localparam logic [1:0] c_PH_GAP = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_SET_SS   = 4'd1,
    S_SSO_ON   = 4'd2,
    S_TX_CMD   = 4'd3,
    S_POLL1    = 4'd4,
    S_RX1      = 4'd5,
    S_TX_DATA  = 4'd6,
    S_POLL2    = 4'd7,
    S_RX2      = 4'd8,
    S_CLR_STAT = 4'd9,
    S_SSO_OFF  = 4'd10,
    S_ACK      = 4'd11
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_phase;
  logic [1:0]      w_phase_nxt;
  logic [CW-1:0]   r_poll_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_poll_last;
  logic            w_to_hit;

  logic            w_any;
  logic [GW-1:0]   w_grant;
  logic [GW-1:0]   r_grant;
  logic            r_wr;
  logic [6:0]      r_addr;
  logic [7:0]      r_wdata;
  logic            r_rrdy;
  logic [7:0]      r_rx_byte;
  logic            r_err;
  logic            r_timeout;
  logic [7:0]      r_rsp_rdata;

  logic            w_bus_wr;
  logic            w_bus_rd;
  logic [2:0]      w_bus_addr;
  logic [15:0]     w_bus_data;
  logic            w_acc;

  // Only RRDY and the two error flags of the status word are of interest.
  logic w_unused;
  assign w_unused = &{1'b0, spi_rdata[15:8], spi_rdata[6:5], spi_rdata[2:0]};

`ifdef RFFE_SPI_SEQ_STRICT_PRIO_EN
  // Fixed priority: lowest requester index wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        w_any   = 1'b1;
        w_grant = GW'(k);
      end
    end
  end
`else
  logic [GW-1:0] r_ptr;
  logic [GW-1:0] w_ptr_nxt;

  // Round-robin: first valid requester at or after the pointer.
  always_comb begin
    int v_idx;
    w_any   = 1'b0;
    w_grant = '0;
    v_idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (req_valid[GW'(v_idx)]) begin
        w_any   = 1'b1;
        w_grant = GW'(v_idx);
      end
    end
  end

  assign w_ptr_nxt = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

  // Pointer advances past the served requester at ack time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (r_state == S_ACK) begin
      r_ptr <= w_ptr_nxt;
    end
  end
`endif

  assign w_poll_last = (int'(r_poll_cnt) + 1) >= POLL_LIMIT;

  // FSM state, access phase and poll counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_poll_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_poll_cnt <= w_cnt_nxt;
    end
  end

  // Next-state logic: every access state steps through its phases, then
  // decides the successor in the gap cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_poll_cnt;
    w_to_hit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_SET_SS;
          w_phase_nxt = '0;
        end
      end
      S_ACK: w_state_nxt = S_IDLE;
      default: begin
        if (r_phase != c_PH_GAP) begin
          w_phase_nxt = r_phase + 2'd1;
        end else begin
          w_phase_nxt = '0;
          case (r_state)
            S_SET_SS: w_state_nxt = S_SSO_ON;
            S_SSO_ON: w_state_nxt = S_TX_CMD;
            S_TX_CMD: begin
              w_state_nxt = S_POLL1;
              w_cnt_nxt   = '0;
            end
            S_POLL1, S_POLL2: begin
              if (r_rrdy) begin
                w_state_nxt = (r_state == S_POLL1) ? S_RX1 : S_RX2;
              end else if (w_poll_last) begin
                w_state_nxt = S_CLR_STAT;
                w_to_hit    = 1'b1;
              end else begin
                w_cnt_nxt = r_poll_cnt + 1'b1;
              end
            end
            S_RX1: w_state_nxt = S_TX_DATA;
            S_TX_DATA: begin
              w_state_nxt = S_POLL2;
              w_cnt_nxt   = '0;
            end
            S_RX2:      w_state_nxt = S_SSO_OFF;
            S_CLR_STAT: w_state_nxt = S_SSO_OFF;
            S_SSO_OFF:  w_state_nxt = S_ACK;
            default:    w_state_nxt = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // Per-state core access decode: direction, register address and data.
  always_comb begin
    w_bus_wr   = 1'b0;
    w_bus_rd   = 1'b0;
    w_bus_addr = 3'd0;
    w_bus_data = 16'h0000;
    case (r_state)
      S_SET_SS:   begin w_bus_wr = 1'b1; w_bus_addr = 3'd5; w_bus_data = SS_MASK;  end
      S_SSO_ON:   begin w_bus_wr = 1'b1; w_bus_addr = 3'd3; w_bus_data = 16'h0400; end
      S_TX_CMD:   begin w_bus_wr = 1'b1; w_bus_addr = 3'd1; w_bus_data = {8'h00, ~r_wr, r_addr}; end
      S_POLL1,
      S_POLL2:    begin w_bus_rd = 1'b1; w_bus_addr = 3'd2; end
      S_RX1,
      S_RX2:      begin w_bus_rd = 1'b1; w_bus_addr = 3'd0; end
      S_TX_DATA:  begin w_bus_wr = 1'b1; w_bus_addr = 3'd1; w_bus_data = {8'h00, r_wr ? r_wdata : 8'h00}; end
      S_CLR_STAT: begin w_bus_wr = 1'b1; w_bus_addr = 3'd2; w_bus_data = 16'h0000; end
      S_SSO_OFF:  begin w_bus_wr = 1'b1; w_bus_addr = 3'd3; w_bus_data = 16'h0000; end
      default:    begin w_bus_wr = 1'b0; end
    endcase
  end

  assign w_acc        = (r_phase != c_PH_GAP) && (w_bus_wr || w_bus_rd);
  assign spi_select   = w_acc;
  assign spi_write_n  = ~(w_acc && w_bus_wr);
  assign spi_read_n   = ~(w_acc && w_bus_rd);
  assign spi_mem_addr = w_acc ? w_bus_addr : 3'd0;
  assign spi_wdata    = w_acc ? w_bus_data : 16'h0000;

  // Grant capture, read-data capture at the end of the 2nd access cycle,
  // and error/timeout tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant     <= '0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rrdy      <= 1'b0;
      r_rx_byte   <= '0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_grant   <= w_grant;
        r_wr      <= req_wr[w_grant];
        r_addr    <= req_addr[7*w_grant +: 7];
        r_wdata   <= req_wdata[8*w_grant +: 8];
        r_err     <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (r_phase == 2'd1) begin
        if (r_state == S_POLL1 || r_state == S_POLL2) begin
          r_rrdy <= spi_rdata[7];
          if (spi_rdata[4] || spi_rdata[3]) r_err <= 1'b1;
        end
        if (r_state == S_RX2) r_rx_byte <= spi_rdata[7:0];
      end
      if (w_to_hit) begin
        r_err     <= 1'b1;
        r_timeout <= 1'b1;
      end
      // Response byte only changes as the ack cycle begins, so it is held
      // from one ack to the next; a timed-out transaction leaves it alone.
      if (r_state == S_SSO_OFF && r_phase == c_PH_GAP && !r_timeout) begin
        r_rsp_rdata <= r_rx_byte;
      end
    end
  end

  // One-cycle ack to the latched grant.
  always_comb begin
    req_ack = '0;
    if (r_state == S_ACK) req_ack[r_grant] = 1'b1;
  end

  assign busy      = (r_state != S_IDLE);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rffe_spi_txn_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rffe_spi_txn_sequencer
// Description : Self-checking bench for rffe_spi_txn_sequencer with a small
//               SPI core register model and a bus protocol monitor.
//               Honours RFFE_SPI_SEQ_STRICT_PRIO_EN for arbitration order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rffe_spi_txn_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_wr = '0;
  logic [13:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_ack;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        spi_select;
  logic        spi_read_n;
  logic        spi_write_n;
  logic [2:0]  spi_mem_addr;
  logic [15:0] spi_wdata;
  logic [15:0] spi_rdata;

  int errors = 0;
  int checks = 0;

  // SPI core model controls
  int         poll_delay = 0;
  bit         stall = 1'b0;
  bit         stat_err = 1'b0;
  logic [7:0] slave_byte = 8'h00;

  // Model/monitor state
  int          polls_since = 0;
  int          n_cmd_since_ss = 0;
  int          run_len = 0;
  logic        a_wr;
  logic [2:0]  a_addr;
  logic [15:0] a_data;
  logic [19:0] acc_log[$];

  rffe_spi_txn_sequencer #(
    .NUM_REQ(2), .POLL_LIMIT(4), .SS_MASK(16'h0001)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .spi_select(spi_select), .spi_read_n(spi_read_n), .spi_write_n(spi_write_n),
    .spi_mem_addr(spi_mem_addr), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata)
  );

  always #5 clk = ~clk;

  // Core read data: status at addr2 (RRDY bit7, TOE bit4), rx byte at addr0.
  always_comb begin
    spi_rdata = 16'h0000;
    if (spi_mem_addr == 3'd2)
      spi_rdata = {8'h00, (!stall && polls_since >= poll_delay), 2'b00, stat_err, 4'b0000};
    else if (spi_mem_addr == 3'd0)
      spi_rdata = {8'h00, (n_cmd_since_ss >= 2) ? slave_byte : 8'h99};
  end

  // Bus monitor: protocol rules, access log and model bookkeeping.
  always @(negedge clk) begin
    if (!reset_n) begin
      run_len = 0;
    end else begin
      if (!spi_read_n && !spi_write_n) begin
        errors++;
        $display("FAIL proto_both_strobes actual=both low required=at most one low");
      end
      if (spi_select) begin
        if (spi_read_n == spi_write_n) begin
          errors++;
          $display("FAIL proto_strobe actual=rd_n %b wr_n %b required=exactly one low", spi_read_n, spi_write_n);
        end
        if (run_len == 0) begin
          a_wr = !spi_write_n; a_addr = spi_mem_addr; a_data = spi_wdata;
        end else if (a_addr != spi_mem_addr || a_data != spi_wdata || a_wr != !spi_write_n) begin
          errors++;
          $display("FAIL proto_stable actual=%h/%h required=%h/%h", spi_mem_addr, spi_wdata, a_addr, a_data);
        end
        run_len++;
      end else begin
        if (!spi_read_n || !spi_write_n) begin
          errors++;
          $display("FAIL proto_idle_strobe actual=strobe low required=both high when deselected");
        end
        if (run_len != 0) begin
          checks++;
          if (run_len != 2) begin
            errors++;
            $display("FAIL proto_len actual=%0d required=2", run_len);
          end
          acc_log.push_back({a_wr, a_addr, a_data});
          if (a_wr && a_addr == 3'd5) n_cmd_since_ss = 0;
          if (a_wr && a_addr == 3'd1) begin n_cmd_since_ss++; polls_since = 0; end
          if (!a_wr && a_addr == 3'd2) polls_since++;
        end
        run_len = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(output int who, output bit ok);
    ok = 1'b0; who = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (req_ack != 2'b00) begin
        ok = 1'b1;
        who = req_ack[0] ? 0 : 1;
        break;
      end
    end
    chk("ack_arrives", {31'd0, ok}, 32'd1);
    if (ok) chk("ack_onehot", {30'd0, req_ack}, (who == 0) ? 32'd1 : 32'd2);
  endtask

  // Collect writes and status-poll count from log position snap onward.
  task automatic scan_log(input int snap, output logic [19:0] wl[$], output int polls);
    wl = {};
    polls = 0;
    for (int i = snap; i < acc_log.size(); i++) begin
      if (acc_log[i][19]) wl.push_back(acc_log[i]);
      else if (acc_log[i][18:16] == 3'd2) polls++;
    end
  endtask

  task automatic chk_writes(input string nm, input logic [19:0] wl[$], input logic [19:0] ex[5]);
    chk({nm, "_nwrites"}, wl.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < wl.size()) chk($sformatf("%s_wr%0d", nm, i), {12'd0, wl[i]}, {12'd0, ex[i]});
  endtask

  typedef struct {
    int         req;
    bit         wr;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] slave;
    int         delay;
    bit         serr;
    logic [15:0] exp_cmd;
    logic [15:0] exp_dat;
    logic [7:0] exp_rdata;
    bit         exp_err;
  } vec_t;

  task automatic set_req(input int r, input bit wr, input logic [6:0] addr, input logic [7:0] wd);
    req_wr[r] = wr;
    req_addr[7*r +: 7] = addr;
    req_wdata[8*r +: 8] = wd;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int snap, who, polls;
    bit ok;
    logic [19:0] wl[$];
    logic [19:0] ex[5];
    string nm;
    nm = $sformatf("vec%0d", n);
    poll_delay = v.delay; stat_err = v.serr; slave_byte = v.slave; stall = 1'b0;
    set_req(v.req, v.wr, v.addr, v.wdata);
    snap = acc_log.size();
    req_valid[v.req] = 1'b1;
    wait_ack(who, ok);
    req_valid[v.req] = 1'b0;
    chk({nm, "_who"}, who, v.req);
    chk({nm, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, v.exp_rdata});
    chk({nm, "_err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
    chk({nm, "_busy_ack"}, {31'd0, busy}, 32'd1);
    scan_log(snap, wl, polls);
    ex = '{{1'b1, 3'd5, 16'h0001}, {1'b1, 3'd3, 16'h0400}, {1'b1, 3'd1, v.exp_cmd},
           {1'b1, 3'd1, v.exp_dat}, {1'b1, 3'd3, 16'h0000}};
    chk_writes(nm, wl, ex);
    chk({nm, "_polls"}, polls, 2 * (v.delay + 1));
    @(negedge clk);
    chk({nm, "_ack_pulse"}, {30'd0, req_ack}, 32'd0);
    chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({nm, "_rdata_hold"}, {24'd0, rsp_rdata}, {24'd0, v.exp_rdata});
  endtask

  initial begin
    vec_t vecs[5];
    int who, snap, polls;
    bit ok, hit;
    int exp_order[4];
    logic [19:0] wl[$];
    logic [19:0] ex[5];

    //            req wr addr    wdata  slave  dly serr  cmd       dat       rdata  err
    vecs[0] = '{0, 1, 7'h12, 8'hA5, 8'h77, 0, 0, 16'h0012, 16'h00A5, 8'h77, 0};
    vecs[1] = '{1, 0, 7'h05, 8'h00, 8'h3C, 2, 0, 16'h0085, 16'h0000, 8'h3C, 0};
    vecs[2] = '{0, 0, 7'h7F, 8'hEE, 8'h81, 1, 0, 16'h00FF, 16'h0000, 8'h81, 0};
    vecs[3] = '{1, 1, 7'h00, 8'hFF, 8'h5A, 3, 1, 16'h0000, 16'h00FF, 8'h5A, 1};
    vecs[4] = '{0, 1, 7'h40, 8'h01, 8'hC3, 0, 0, 16'h0040, 16'h0001, 8'hC3, 0};

`ifdef RFFE_SPI_SEQ_STRICT_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif

    // Reset values, with both requesters already pending.
    set_req(0, 1'b1, 7'h12, 8'hA5);
    set_req(1, 1'b0, 7'h05, 8'h00);
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_select", {31'd0, spi_select}, 32'd0);
    chk("rst_strobes", {30'd0, spi_read_n, spi_write_n}, 32'd3);
    chk("rst_addr_data", {13'd0, spi_mem_addr, spi_wdata}, 32'd0);
    chk("rst_ack_busy", {28'd0, req_ack, rsp_err, busy}, 32'd0);
    chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    @(posedge clk); #2 reset_n = 1'b1;

    // Arbitration order with both requests held.
    for (int t = 0; t < 4; t++) begin
      wait_ack(who, ok);
      chk($sformatf("arb_grant%0d", t), who, exp_order[t]);
      if (t == 3) req_valid = 2'b00;
    end
    @(negedge clk);

    // Directed single transactions.
    for (int n = 0; n < 5; n++) run_vec(vecs[n], n);

    // Poll timeout: RRDY never set.
    stall = 1'b1; stat_err = 1'b0; poll_delay = 0;
    set_req(1, 1'b0, 7'h05, 8'h00);
    snap = acc_log.size();
    req_valid[1] = 1'b1;
    wait_ack(who, ok);
    req_valid[1] = 1'b0;
    chk("to_who", who, 1);
    chk("to_err", {31'd0, rsp_err}, 32'd1);
    chk("to_rdata_kept", {24'd0, rsp_rdata}, {24'd0, vecs[4].exp_rdata});
    scan_log(snap, wl, polls);
    ex = '{{1'b1, 3'd5, 16'h0001}, {1'b1, 3'd3, 16'h0400}, {1'b1, 3'd1, 16'h0085},
           {1'b1, 3'd2, 16'h0000}, {1'b1, 3'd3, 16'h0000}};
    chk_writes("to", wl, ex);
    chk("to_polls", polls, 4);
    if (acc_log.size() >= 2) chk("to_clr_after_poll", {12'd0, acc_log[acc_log.size()-3]}, {12'd0, 1'b0, 3'd2, 16'h0000});
    @(negedge clk);
    stall = 1'b0;

    // Reset asserted during the second status poll phase.
    poll_delay = 3; slave_byte = 8'h6D;
    set_req(0, 1'b1, 7'h12, 8'hA5);
    snap = acc_log.size();
    req_valid[0] = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge clk);
      if (acc_log.size() > snap && n_cmd_since_ss == 2 && polls_since >= 1) hit = 1'b1;
    end
    chk("rp_reach_poll2", {31'd0, hit}, 32'd1);
    chk("rp_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("rp_select", {31'd0, spi_select}, 32'd0);
    chk("rp_strobes", {30'd0, spi_read_n, spi_write_n}, 32'd3);
    chk("rp_addr_data", {13'd0, spi_mem_addr, spi_wdata}, 32'd0);
    chk("rp_ack_err_busy", {28'd0, req_ack, rsp_err, busy}, 32'd0);
    chk("rp_rdata", {24'd0, rsp_rdata}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rp_no_ack_in_reset", {30'd0, req_ack}, 32'd0);
    end
    @(posedge clk); #2 reset_n = 1'b1;
    snap = acc_log.size();
    wait_ack(who, ok);
    req_valid[0] = 1'b0;
    chk("rp_who", who, 0);
    chk("rp_err_after", {31'd0, rsp_err}, 32'd0);
    chk("rp_rdata_after", {24'd0, rsp_rdata}, 32'h6D);
    scan_log(snap, wl, polls);
    ex = '{{1'b1, 3'd5, 16'h0001}, {1'b1, 3'd3, 16'h0400}, {1'b1, 3'd1, 16'h0012},
           {1'b1, 3'd1, 16'h00A5}, {1'b1, 3'd3, 16'h0000}};
    chk_writes("rp", wl, ex);
    chk("rp_polls", polls, 8);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rffe_spi_txn_sequencer.md
Name: rffe_spi_txn_sequencer

Overview:
- Hardware master for the 8-bit RFFE SPI master core's 3-bit register port.
- Arbitrates NUM_REQ requesters (NIOS bridge, DVB-T2 AGC, ...) and runs one complete 2-byte register transaction per grant: address/command byte, then data byte, with SS held low throughout.
- Returns the read byte to the granted requester and acks it; sits between the requesters and the SPI core in place of direct CPU access.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- POLL_LIMIT, 255, maximum status polls per byte before timeout.
- SS_MASK, 16'h0001, value written to slave-enable register (addr 5).

Ports:
- clk  in  1  system clock, same clock as the SPI core
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  request pending; held until matching req_ack
- req_wr  in  NUM_REQ  1 = register write, 0 = register read
- req_addr  in  NUM_REQ*7  7-bit register address per requester, flattened, requester i at [7i+6:7i]
- req_wdata  in  NUM_REQ*8  write data per requester, flattened
- req_ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- rsp_rdata  out  8  second received byte; valid in the req_ack cycle and held until the next ack
- rsp_err  out  1  poll timeout on the acked transaction; valid with req_ack
- busy  out  1  high from grant through the ack cycle
- spi_select  out  1  SPI core chip select
- spi_read_n  out  1  SPI core read strobe, active low
- spi_write_n  out  1  SPI core write strobe, active low
- spi_mem_addr  out  3  SPI core register address
- spi_wdata  out  16  SPI core write data
- spi_rdata  in  16  SPI core read data

Behaviour:
- Reset values:
  - spi_select=0, spi_read_n=1, spi_write_n=1, spi_mem_addr=0, spi_wdata=0.
  - req_ack=0, rsp_rdata=0, rsp_err=0, busy=0.
  - FSM in IDLE, round-robin pointer=0.
- Reset mid-transaction: the SPI core shares reset_n, so SSO and SS are released; no partial ack is issued.
- Bus access: every core access is exactly 2 cycles.
  - spi_select=1 and the strobe low for both cycles, with address and data stable.
  - Read data is captured at the clock edge that ends the 2nd cycle (the core registers data_to_cpu).
  - At least 1 idle cycle (select=0, both strobes high) between accesses.
  - Read and write strobes are never low together.
- Arbitration (IDLE):
  - Round-robin starting at pointer; the grant is latched for the whole transaction.
  - Pointer becomes grant+1 mod NUM_REQ at ack.
  - Request fields are sampled once at grant.
  - Dropping req_valid mid-transaction does not abort; the ack is still pulsed.
- FSM states: IDLE -> SET_SS -> SSO_ON -> TX_CMD -> POLL1 -> RX1 -> TX_DATA -> POLL2 -> RX2 -> SSO_OFF -> ACK -> IDLE.
  - SET_SS: write addr5 = SS_MASK.
  - SSO_ON: write addr3 = 16'h0400 (SSO=1).
  - TX_CMD: write addr1 = {8'h00, ~wr, addr[6:0]} (bit7=1 means read).
  - POLL1/POLL2: read addr2; if status bit7 (RRDY)=1, advance; else increment poll_cnt and repeat.
  - RX1: read addr0; discard the data.
  - TX_DATA: write addr1 = wdata for a write, 8'h00 for a read.
  - RX2: read addr0; latch [7:0] into rsp_rdata.
  - SSO_OFF: write addr3 = 16'h0000.
  - ACK: req_ack[grant]=1 for 1 cycle; busy falls the next cycle.
- Timeout:
  - poll_cnt is 8 bits or wider, cleared on entry to each POLL state.
  - When poll_cnt reaches POLL_LIMIT without RRDY: write addr2 (clears the core status), then SSO_OFF, then ACK with rsp_err=1.
  - rsp_rdata is unchanged on timeout.
- Status error bits (TOE/ROE, status bits 4/3) seen during a poll also set rsp_err, but the sequence continues.
- New requests arriving in the ACK cycle are arbitrated in the following IDLE cycle; minimum gap between transactions is 1 idle cycle.

Optional Feature:
- RFFE_SPI_SEQ_STRICT_PRIO_EN
  - Defined: fixed priority, lowest index wins. Requester 0 (AGC) always preempts at arbitration; an in-flight transaction is never aborted. The round-robin pointer is removed.
  - Undefined: round-robin as specified above.

Test Plan:
- Single write, req 0: addr=7'h12, wdata=8'hA5.
  - Core sees addr5←0x0001, addr3←0x0400, addr1←0x0012, addr1←0x00A5, addr3←0x0000, in that order.
  - Each write is exactly 2 cycles; 1 req_ack[0] pulse; rsp_err=0.
- Single read, req 1: addr=7'h05, slave model returns 8'h3C on the 2nd byte.
  - addr1 receives 0x0085 then 0x0000.
  - rsp_rdata=8'h3C in the req_ack[1] cycle.
  - MOSI bytes are 0x85, 0x00; SS_n is low continuously across both bytes.
- Both requesters valid from reset.
  - Grant order is 0, 1, 0, 1 over 4 transactions, with exactly one ack per transaction.
  - With RFFE_SPI_SEQ_STRICT_PRIO_EN defined: order is 0, 0, 0 while req 0 stays asserted.
- Timeout: SPI model with the transmitter stalled (RRDY never set), POLL_LIMIT=4.
  - Exactly 4 status polls, then a write to addr2, then addr3←0x0000, then req_ack with rsp_err=1.
- Reset asserted during POLL2.
  - All outputs return to reset values asynchronously; no ack is issued.
  - After release, a pending request restarts from SET_SS.
- Protocol checker for the entire run:
  - Never both strobes low.
  - Select is never asserted for other than 2 consecutive cycles.
  - A gap of at least 1 cycle follows every access.
